// File: rtl/csi_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csi_sync_pkg
// Brief    : State, error-code and channel encodings for csi_sync_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package csi_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_ARM     = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [2:0] c_err_none    = 3'd0;
    localparam logic [2:0] c_err_timeout = 3'd1;
    localparam logic [2:0] c_err_orphan  = 3'd2;
    localparam logic [2:0] c_err_drift   = 3'd3;
    localparam logic [2:0] c_err_ovf     = 3'd4;
    localparam logic [2:0] c_err_udf     = 3'd5;

    localparam logic [1:0] c_ch_none = 2'd0;
    localparam logic [1:0] c_ch1     = 2'd1;
    localparam logic [1:0] c_ch2     = 2'd2;
    localparam logic [1:0] c_ch_both = 2'd3;

    // Pair measurement only runs while the controller is tracking frames.
    function automatic logic meas_active(input state_t s);
        return (s == ST_MEASURE) || (s == ST_ARM) || (s == ST_LOCKED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csi_sync_ctrl_if
// Brief    : Control/status bundle between csi_sync_ctrl and its environment.
//            Stats fields exist only when CSI_SYNC_CTRL_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface csi_sync_ctrl_if #(
    parameter int SKEW_W = 12
);
    logic              run;
    logic              sof1;
    logic              sof2;
    logic              fifo_ovf;
    logic              fifo_udf;
    logic              enb;
    logic              locked;
    logic [2:0]        state;
    logic [SKEW_W-1:0] skew;
    logic [1:0]        skew_ch;
    logic [2:0]        err_code;
`ifdef CSI_SYNC_CTRL_STATS_EN
    logic [15:0]       frm_cnt;
    logic [7:0]        err_cnt;

    modport master (
        output run, sof1, sof2, fifo_ovf, fifo_udf,
        input  enb, locked, state, skew, skew_ch, err_code, frm_cnt, err_cnt
    );
    modport slave (
        input  run, sof1, sof2, fifo_ovf, fifo_udf,
        output enb, locked, state, skew, skew_ch, err_code, frm_cnt, err_cnt
    );
`else
    modport master (
        output run, sof1, sof2, fifo_ovf, fifo_udf,
        input  enb, locked, state, skew, skew_ch, err_code
    );
    modport slave (
        input  run, sof1, sof2, fifo_ovf, fifo_udf,
        output enb, locked, state, skew, skew_ch, err_code
    );
`endif
endinterface
`default_nettype wire

// File: rtl/csi_sync_ctrl_skew_meas.sv
`default_nettype none
// ============================================================================
// Module   : csi_skew_meas
// Brief    : SOF pair tracker: skew counter, pair close, TIMEOUT/ORPHAN pulses.
// Revision : 1.0 - initial release
// ============================================================================
module csi_skew_meas
    import csi_sync_pkg::*;
#(
    parameter int SKEW_MAX = 512,
    parameter int SKEW_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              sof1,
    input  logic              sof2,
    output logic              pair_done,
    output logic [SKEW_W-1:0] pair_skew,
    output logic [1:0]        pair_ch,
    output logic              timeout,
    output logic              orphan
);

    logic              r_open;
    logic [1:0]        r_first;
    logic [SKEW_W-1:0] r_cnt;
    logic [SKEW_W-1:0] w_elapsed;
    logic              w_same;
    logic              w_other;

    // r_cnt holds cycles since the opening SOF minus one, so the value seen
    // in the closing cycle is the true SOF-to-SOF distance.
    assign w_elapsed = r_cnt + SKEW_W'(1);
    assign w_same    = (r_first == c_ch1) ? sof1 : sof2;
    assign w_other   = (r_first == c_ch1) ? sof2 : sof1;

    always_comb begin
        pair_done = 1'b0;
        pair_skew = '0;
        pair_ch   = c_ch_none;
        timeout   = 1'b0;
        orphan    = 1'b0;
        if (active) begin
            if (!r_open) begin
                if (sof1 && sof2) begin
                    pair_done = 1'b1;
                    pair_ch   = c_ch_both;
                end
            end else if (w_same) begin
                orphan = 1'b1;
            end else if (w_other) begin
                pair_done = 1'b1;
                pair_skew = w_elapsed;
                pair_ch   = r_first;
            end else if (w_elapsed >= SKEW_W'(SKEW_MAX)) begin
                timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            r_open  <= 1'b0;
            r_first <= c_ch_none;
            r_cnt   <= '0;
        end else if (!r_open) begin
            if (sof1 ^ sof2) begin
                r_open  <= 1'b1;
                r_first <= sof1 ? c_ch1 : c_ch2;
                r_cnt   <= '0;
            end
        end else if (pair_done || orphan || timeout) begin
            r_open  <= 1'b0;
            r_first <= c_ch_none;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_elapsed;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csi_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csi_sync_ctrl
// Brief    : Stereo CSI frame-sync controller gating the csi_dly aligner.
//            Optional stats counters: define CSI_SYNC_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csi_sync_ctrl
    import csi_sync_pkg::*;
#(
    parameter int SKEW_MAX    = 512,
    parameter int SKEW_W      = 12,
    parameter int SKEW_TOL    = 2,
    parameter int LOCK_FRAMES = 2,
    parameter int DROP_CYC    = 16
) (
    input  logic            clk,
    input  logic            rst,
    csi_sync_ctrl_if.slave  bus
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 2);
    localparam int DROP_W = $clog2(DROP_CYC + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_err;
    logic [2:0]        w_err_nxt;
    logic [2:0]        w_fault;
    logic [SKEW_W-1:0] r_skew;
    logic [1:0]        r_skew_ch;
    logic [SKEW_W-1:0] r_ref_skew;
    logic [SKEW_W-1:0] w_ref_skew_nxt;
    logic [1:0]        r_ref_ch;
    logic [1:0]        w_ref_ch_nxt;
    logic              r_ref_valid;
    logic              w_ref_valid_nxt;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [DROP_W-1:0] r_drop;
    logic [DROP_W-1:0] w_drop_nxt;
    logic              r_ovf_d;
    logic              r_udf_d;

    logic              w_meas_active;
    logic              w_pair_done;
    logic [SKEW_W-1:0] w_pair_skew;
    logic [1:0]        w_pair_ch;
    logic              w_timeout;
    logic              w_orphan;
    logic [SKEW_W-1:0] w_diff;
    logic              w_in_tol;
    logic              w_ovf_rise;
    logic              w_udf_rise;

    assign w_meas_active = meas_active(r_state);

    csi_skew_meas #(
        .SKEW_MAX (SKEW_MAX),
        .SKEW_W   (SKEW_W)
    ) u_meas (
        .clk       (clk),
        .rst       (rst),
        .active    (w_meas_active),
        .sof1      (bus.sof1),
        .sof2      (bus.sof2),
        .pair_done (w_pair_done),
        .pair_skew (w_pair_skew),
        .pair_ch   (w_pair_ch),
        .timeout   (w_timeout),
        .orphan    (w_orphan)
    );

    assign w_diff     = (w_pair_skew >= r_ref_skew) ? (w_pair_skew - r_ref_skew)
                                                    : (r_ref_skew - w_pair_skew);
    assign w_in_tol   = (w_pair_ch == r_ref_ch) && (w_diff <= SKEW_W'(SKEW_TOL));
    assign w_ovf_rise = bus.fifo_ovf & ~r_ovf_d;
    assign w_udf_rise = bus.fifo_udf & ~r_udf_d;

    always_comb begin
        w_state_nxt     = r_state;
        w_err_nxt       = r_err;
        w_ref_skew_nxt  = r_ref_skew;
        w_ref_ch_nxt    = r_ref_ch;
        w_ref_valid_nxt = r_ref_valid;
        w_good_nxt      = r_good;
        w_drop_nxt      = r_drop;
        w_fault         = c_err_none;

        case (r_state)
            ST_IDLE: begin
                if (bus.run) begin
                    w_state_nxt     = ST_MEASURE;
                    w_err_nxt       = c_err_none;
                    w_good_nxt      = '0;
                    w_ref_valid_nxt = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (w_timeout) begin
                    w_fault = c_err_timeout;
                end else if (w_orphan) begin
                    w_fault = c_err_orphan;
                end else if (w_pair_done) begin
                    // A mismatching pair becomes the new reference and counts once.
                    if (r_ref_valid && w_in_tol) begin
                        w_good_nxt = r_good + GOOD_W'(1);
                    end else begin
                        w_ref_skew_nxt  = w_pair_skew;
                        w_ref_ch_nxt    = w_pair_ch;
                        w_ref_valid_nxt = 1'b1;
                        w_good_nxt      = r_ref_valid ? GOOD_W'(1) : '0;
                    end
                    if (w_good_nxt >= GOOD_W'(LOCK_FRAMES)) begin
                        w_state_nxt = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (w_timeout) begin
                    w_fault = c_err_timeout;
                end else if (w_orphan) begin
                    w_fault = c_err_orphan;
                end else if (w_pair_done) begin
                    if (w_in_tol) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_fault = c_err_drift;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_ovf_rise) begin
                    w_fault = c_err_ovf;
                end else if (w_udf_rise) begin
                    w_fault = c_err_udf;
                end else if (w_timeout) begin
                    w_fault = c_err_timeout;
                end else if (w_orphan) begin
                    w_fault = c_err_orphan;
                end else if (w_pair_done && !w_in_tol) begin
                    w_fault = c_err_drift;
                end
            end
            ST_FAULT: begin
                if (r_drop == DROP_W'(DROP_CYC - 1)) begin
                    w_state_nxt = bus.run ? ST_MEASURE : ST_IDLE;
                    w_drop_nxt  = '0;
                end else begin
                    w_drop_nxt = r_drop + DROP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_fault != c_err_none) begin
            w_state_nxt     = ST_FAULT;
            w_err_nxt       = w_fault;
            w_drop_nxt      = '0;
            w_ref_valid_nxt = 1'b0;
            w_good_nxt      = '0;
        end

        // Dropping run wins over everything but leaves the last cause visible.
        if (!bus.run) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = r_err;
            w_drop_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_err       <= c_err_none;
            r_skew      <= '0;
            r_skew_ch   <= c_ch_none;
            r_ref_skew  <= '0;
            r_ref_ch    <= c_ch_none;
            r_ref_valid <= 1'b0;
            r_good      <= '0;
            r_drop      <= '0;
            r_ovf_d     <= 1'b0;
            r_udf_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err       <= w_err_nxt;
            r_ref_skew  <= w_ref_skew_nxt;
            r_ref_ch    <= w_ref_ch_nxt;
            r_ref_valid <= w_ref_valid_nxt;
            r_good      <= w_good_nxt;
            r_drop      <= w_drop_nxt;
            r_ovf_d     <= bus.fifo_ovf;
            r_udf_d     <= bus.fifo_udf;
            if (w_pair_done) begin
                r_skew    <= w_pair_skew;
                r_skew_ch <= w_pair_ch;
            end
        end
    end

    assign bus.enb      = (r_state == ST_ARM) || (r_state == ST_LOCKED);
    assign bus.locked   = (r_state == ST_LOCKED);
    assign bus.state    = r_state;
    assign bus.skew     = r_skew;
    assign bus.skew_ch  = r_skew_ch;
    assign bus.err_code = r_err;

`ifdef CSI_SYNC_CTRL_STATS_EN
    logic [15:0] r_frm_cnt;
    logic [7:0]  r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_MEASURE)) begin
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if ((r_state == ST_LOCKED) && w_pair_done) begin
                r_frm_cnt <= r_frm_cnt + 16'd1;
            end
            if ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.frm_cnt = r_frm_cnt;
    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire
